// File: rtl/deser_frame_ctrl_pkg.sv
// Shared types and constants for the deserializer frame controller.
// Holds the FSM state encoding and the bit-counter width helper.
package deser_frame_ctrl_pkg;

    localparam int DEF_LENGTH = 24;
    localparam int DEF_ERR_W  = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HUNT  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_HUNT  = HUNT,
        ST_SHIFT = SHIFT
    } state_t;

    function automatic int cnt_width(input int len);
        return (len > 2) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/deser_frame_ctrl_if.sv
// Sample hand-off bus between the frame controller and the FIR core.
// The master holds the sample; the slave supplies ready.
interface deser_frame_ctrl_if
    import deser_frame_ctrl_pkg::*;
#(
    parameter int LENGTH = DEF_LENGTH
);

    logic [LENGTH-1:0] ov_sample;
    logic              o_sample_valid;
    logic              i_sample_ready;

    modport master (
        output ov_sample,
        output o_sample_valid,
        input  i_sample_ready
    );

    modport slave (
        input  ov_sample,
        input  o_sample_valid,
        output i_sample_ready
    );

endinterface

// File: rtl/deser_frame_ctrl_sample_buf.sv
// One-entry holding register fed by rising edges of the deserializer
// word-valid level, with valid/ready hand-off and overrun detection.
module deser_sample_buf
    import deser_frame_ctrl_pkg::*;
#(
    parameter int LENGTH = DEF_LENGTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [LENGTH-1:0] iv_dout,
    input  logic              i_dout_valid,
    deser_frame_ctrl_if.master smp,
    output logic              o_overrun
);

    logic dout_valid_q;
    logic capture;

    assign capture = i_dout_valid & ~dout_valid_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dout_valid_q       <= 1'b0;
            smp.ov_sample      <= '0;
            smp.o_sample_valid <= 1'b0;
            o_overrun          <= 1'b0;
        end else begin
            dout_valid_q <= i_dout_valid;
            o_overrun    <= 1'b0;
            if (capture) begin
                // A full buffer only takes the new word if it drains now.
                if (!smp.o_sample_valid || smp.i_sample_ready) begin
                    smp.ov_sample      <= iv_dout;
                    smp.o_sample_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (smp.i_sample_ready) begin
                smp.o_sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/deser_frame_ctrl.sv
// Frames an LSB-first serial stream for the deserializer and hands the
// captured words to the FIR core; counts framing errors and overruns.
module deser_frame_ctrl
    import deser_frame_ctrl_pkg::*;
#(
    parameter int LENGTH = DEF_LENGTH,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_bit_stb,
    input  logic              i_sdata,
    input  logic              i_frame_sync,
    output logic              o_deser_en,
    output logic              o_deser_din,
    output logic              o_deser_din_valid,
    input  logic [LENGTH-1:0] iv_deser_dout,
    input  logic              i_deser_dout_valid,
    deser_frame_ctrl_if.master smp,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic [ERR_W-1:0]  ov_err_cnt
);

    localparam int CNT_W = cnt_width(LENGTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             fwd;
    logic             last;
    logic             ferr;
    logic [ERR_W:0]   err_sum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        fwd     = 1'b0;
        last    = 1'b0;
        ferr    = 1'b0;
        if (!i_run) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_n = ST_HUNT;
                    cnt_n   = '0;
                end
                ST_HUNT: begin
                    if (i_bit_stb && i_frame_sync) begin
                        fwd     = 1'b1;
                        cnt_n   = CNT_W'(1);
                        state_n = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (i_bit_stb) begin
                        if (bit_cnt == '0 && !i_frame_sync) begin
                            ferr    = 1'b1;
                            cnt_n   = '0;
                            state_n = ST_HUNT;
                        end else if (i_frame_sync) begin
                            // Partial bits get shifted out before the next word-valid.
                            fwd   = 1'b1;
                            ferr  = (bit_cnt != '0);
                            cnt_n = CNT_W'(1);
                        end else begin
                            fwd = 1'b1;
                            if (bit_cnt == LAST) begin
                                last  = 1'b1;
                                cnt_n = '0;
                            end else begin
                                cnt_n = bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign err_sum = {1'b0, ov_err_cnt}
                   + {{ERR_W{1'b0}}, o_frame_err}
                   + {{ERR_W{1'b0}}, o_overrun};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_deser_en        <= 1'b0;
            o_deser_din       <= 1'b0;
            o_deser_din_valid <= 1'b0;
            o_frame_err       <= 1'b0;
            ov_err_cnt        <= '0;
        end else begin
            o_deser_en        <= fwd;
            o_deser_din       <= fwd & i_sdata;
            o_deser_din_valid <= last;
            o_frame_err       <= ferr;
            ov_err_cnt        <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        end
    end

    deser_sample_buf #(
        .LENGTH (LENGTH)
    ) u_buf (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .iv_dout      (iv_deser_dout),
        .i_dout_valid (i_deser_dout_valid),
        .smp          (smp),
        .o_overrun    (o_overrun)
    );

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Bench for deser_frame_ctrl with a behavioural LSB-first deserializer,
// directed vectors, hand sequences and a randomized framing model.
module tb_deser_frame_ctrl;

    localparam int L  = 24;
    localparam int EW = 8;

    typedef struct {
        logic [L-1:0] pre;
        int           pre_len;
        logic         pre_sync;
        logic [L-1:0] word;
        logic [L-1:0] exp_word;
        int           exp_ferr;
    } vec_t;

    typedef struct {
        logic b;
        logic s;
    } stb_t;

    logic          clk;
    logic          rst;
    logic          run;
    logic          stb;
    logic          sdata;
    logic          sync;
    logic          deser_en;
    logic          deser_din;
    logic          deser_din_valid;
    logic [L-1:0]  deser_dout;
    logic          deser_dout_valid;
    logic          frame_err;
    logic          overrun;
    logic [EW-1:0] err_cnt;
    logic [L-1:0]  des_sr;
    logic [L-1:0]  des_nxt;

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
    int ovr_seen = 0;
    logic [L-1:0] got[$];

    int model_pos;
    logic [L-1:0] model_acc;
    int model_ferr;
    logic [L-1:0] exp_q[$];

    deser_frame_ctrl_if #(.LENGTH(L)) smp ();

    deser_frame_ctrl #(
        .LENGTH (L),
        .ERR_W  (EW)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_run              (run),
        .i_bit_stb          (stb),
        .i_sdata            (sdata),
        .i_frame_sync       (sync),
        .o_deser_en         (deser_en),
        .o_deser_din        (deser_din),
        .o_deser_din_valid  (deser_din_valid),
        .iv_deser_dout      (deser_dout),
        .i_deser_dout_valid (deser_dout_valid),
        .smp                (smp),
        .o_frame_err        (frame_err),
        .o_overrun          (overrun),
        .ov_err_cnt         (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Deserializer: LSB-first, synchronous reset, word-valid level held
    assign des_nxt = {deser_din, des_sr[L-1:1]};
    always @(posedge clk) begin
        if (rst) begin
            des_sr           <= '0;
            deser_dout       <= '0;
            deser_dout_valid <= 1'b0;
        end else if (deser_en) begin
            des_sr           <= des_nxt;
            deser_dout_valid <= deser_din_valid;
            if (deser_din_valid) deser_dout <= des_nxt;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (smp.o_sample_valid && smp.i_sample_ready)
                got.push_back(smp.ov_sample);
            if (frame_err) ferr_seen <= ferr_seen + 1;
            if (overrun) ovr_seen <= ovr_seen + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b, input logic s, input int gap);
        stb = 1'b1;
        sdata = b;
        sync = s;
        tick;
        stb = 1'b0;
        sdata = 1'b0;
        sync = 1'b0;
        repeat (gap) tick;
    endtask

    task automatic send_bits(input logic [L-1:0] w, input int n, input logic s);
        for (int i = 0; i < n; i++) strobe(w[i], s && (i == 0), 0);
    endtask

    task automatic send_word(input logic [L-1:0] w);
        send_bits(w, L, 1'b1);
    endtask

    function automatic logic [L-1:0] pop_got();
        if (got.size() == 0) return 'x;
        return got.pop_front();
    endfunction

    // Framing rules applied to the abstract strobe stream
    task automatic model_step(input logic b, input logic s);
        if (model_pos < 0) begin
            if (s) begin
                model_acc = '0;
                model_acc[0] = b;
                model_pos = 1;
            end
        end else if (model_pos == 0 && !s) begin
            model_ferr++;
            model_pos = -1;
        end else begin
            if (s) begin
                if (model_pos != 0) model_ferr++;
                model_acc = '0;
                model_acc[0] = b;
                model_pos = 1;
            end else begin
                model_acc[model_pos] = b;
                model_pos++;
            end
            if (model_pos == L) begin
                exp_q.push_back(model_acc);
                model_pos = 0;
            end
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, 64'({deser_en, deser_din, deser_din_valid,
            smp.o_sample_valid, frame_err, overrun}), 64'(0));
        chk({name, "_sample"}, 64'(smp.ov_sample), 64'(0));
        chk({name, "_errcnt"}, 64'(err_cnt), 64'(0));
    endtask

    initial begin
        vec_t vt[6];
        stb_t sq[$];
        logic [L-1:0] w;
        int f0, o0, mf0, n, kind, junk, mid, err_exp;

        vt[0] = '{24'h000000, 3,  1'b0, 24'hA5C3F0, 24'hA5C3F0, 0};
        vt[1] = '{24'h000000, 0,  1'b0, 24'h000001, 24'h000001, 0};
        vt[2] = '{24'h000000, 0,  1'b0, 24'h800000, 24'h800000, 0};
        vt[3] = '{24'hFFFFFF, 10, 1'b1, 24'h123456, 24'h123456, 1};
        vt[4] = '{24'h00001F, 5,  1'b0, 24'h5A5A5A, 24'h5A5A5A, 1};
        vt[5] = '{24'h000003, 23, 1'b1, 24'hC0FFEE, 24'hC0FFEE, 1};

        rst = 1'b1;
        run = 1'b0;
        stb = 1'b0;
        sdata = 1'b0;
        sync = 1'b0;
        smp.i_sample_ready = 1'b1;
        err_exp = 0;
        model_pos = -1;
        model_acc = '0;
        model_ferr = 0;
        repeat (3) tick;
        chk_zero("reset");
        rst = 1'b0;
        run = 1'b1;
        tick;
        tick;

        for (int i = 0; i < 6; i++) begin
            f0 = ferr_seen;
            send_bits(vt[i].pre, vt[i].pre_len, vt[i].pre_sync);
            send_word(vt[i].word);
            tick;
            chk($sformatf("vec%0d_valid_early", i), 64'(smp.o_sample_valid), 64'(0));
            tick;
            chk($sformatf("vec%0d_valid", i), 64'(smp.o_sample_valid), 64'(1));
            chk($sformatf("vec%0d_sample", i), 64'(smp.ov_sample), 64'(vt[i].exp_word));
            err_exp += vt[i].exp_ferr;
            chk($sformatf("vec%0d_ferr", i), 64'(ferr_seen - f0), 64'(vt[i].exp_ferr));
            chk($sformatf("vec%0d_errcnt", i), 64'(err_cnt), 64'(err_exp));
            tick;
            tick;
        end

        // Back-to-back words with no idle strobe slot between them
        got.delete();
        o0 = ovr_seen;
        send_word(24'h000001);
        send_word(24'h800000);
        repeat (4) tick;
        chk("b2b_count", 64'(got.size()), 64'(2));
        chk("b2b_first", 64'(pop_got()), 64'(24'h000001));
        chk("b2b_second", 64'(pop_got()), 64'(24'h800000));
        chk("b2b_overrun", 64'(ovr_seen - o0), 64'(0));

        // Stalled consumer across two words
        got.delete();
        smp.i_sample_ready = 1'b0;
        o0 = ovr_seen;
        send_word(24'h111111);
        send_word(24'h222222);
        repeat (4) tick;
        chk("stall_sample", 64'(smp.ov_sample), 64'(24'h111111));
        chk("stall_valid", 64'(smp.o_sample_valid), 64'(1));
        chk("stall_overrun", 64'(ovr_seen - o0), 64'(1));
        err_exp++;
        chk("stall_errcnt", 64'(err_cnt), 64'(err_exp));
        smp.i_sample_ready = 1'b1;
        tick;
        chk("stall_drain_valid", 64'(smp.o_sample_valid), 64'(0));
        chk("stall_drain_word", 64'(pop_got()), 64'(24'h111111));

        // Run dropped mid-word
        got.delete();
        f0 = ferr_seen;
        send_bits(24'hFFFFFF, 12, 1'b1);
        run = 1'b0;
        tick;
        tick;
        run = 1'b1;
        tick;
        tick;
        send_word(24'hABCDEF);
        repeat (4) tick;
        chk("run_count", 64'(got.size()), 64'(1));
        chk("run_word", 64'(pop_got()), 64'(24'hABCDEF));
        chk("run_ferr", 64'(ferr_seen - f0), 64'(0));

        // Asynchronous reset mid-word
        send_bits(24'h5A5A5A, 8, 1'b1);
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        tick;
        tick;
        rst = 1'b0;
        tick;
        tick;
        err_exp = 0;
        model_pos = -1;
        model_ferr = 0;
        exp_q.delete();

        // Randomized framing against the abstract model
        for (int f = 0; f < 16; f++) begin
            w = L'($urandom);
            kind = (f == 15) ? 9 : $urandom_range(0, 5);
            n = L;
            junk = 0;
            mid = 0;
            if (kind == 0) n = $urandom_range(2, L - 1);
            if (kind == 1) junk = $urandom_range(1, 4);
            if (kind == 2) mid = $urandom_range(1, L - 1);
            for (int i = 0; i < n; i++)
                sq.push_back('{b: w[i], s: (i == 0) || (mid != 0 && i == mid)});
            for (int j = 0; j < junk; j++)
                sq.push_back('{b: 1'($urandom), s: 1'b0});
        end
        got.delete();
        f0 = ferr_seen;
        o0 = ovr_seen;
        foreach (sq[k]) begin
            model_step(sq[k].b, sq[k].s);
            strobe(sq[k].b, sq[k].s, $urandom_range(0, 2));
        end
        repeat (6) tick;
        n = exp_q.size();
        chk("rand_count", 64'(got.size()), 64'(n));
        for (int k = 0; k < n; k++)
            chk($sformatf("rand_word%0d", k), 64'(pop_got()), 64'(exp_q[k]));
        chk("rand_ferr", 64'(ferr_seen - f0), 64'(model_ferr));
        chk("rand_overrun", 64'(ovr_seen - o0), 64'(0));
        err_exp = (model_ferr > 255) ? 255 : model_ferr;
        chk("rand_errcnt", 64'(err_cnt), 64'(err_exp));

        // Continuous early syncs drive the counter into saturation
        f0 = ferr_seen;
        mf0 = model_ferr;
        for (int k = 0; k < 300; k++) begin
            w[0] = 1'($urandom);
            model_step(w[0], 1'b1);
            strobe(w[0], 1'b1, 0);
        end
        repeat (4) tick;
        chk("sat_ferr", 64'(ferr_seen - f0), 64'(model_ferr - mf0));
        err_exp = err_exp + (model_ferr - mf0);
        if (err_exp > 255) err_exp = 255;
        chk("sat_errcnt", 64'(err_cnt), 64'(err_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deser_frame_ctrl.md
Name: deser_frame_ctrl

Overview:
Sequencer for the FIR front-end serial-to-parallel deserializer. It frames an LSB-first serial sample stream using a bit strobe and a frame-sync marker, and drives the deserializer's enable, data and word-valid inputs. It edge-captures each completed word into a one-entry holding register with a valid/ready handshake to the FIR core. It also flags framing errors and overruns.

Parameters:
LENGTH, 24, bits per sample word; must match the deserializer; legal range >= 2
ERR_W, 8, width of the saturating error counter

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_run  in  1  level; 1 = receive enabled
i_bit_stb  in  1  one-cycle strobe; one serial bit valid this cycle
i_sdata  in  1  serial data bit, qualified by i_bit_stb
i_frame_sync  in  1  qualified by i_bit_stb; marks bit 0 (LSB) of a word
o_deser_en  out  1  to deserializer i_en
o_deser_din  out  1  to deserializer i_din
o_deser_din_valid  out  1  to deserializer i_din_valid
iv_deser_dout  in  LENGTH  from deserializer ov_dout
i_deser_dout_valid  in  1  from deserializer o_dout_valid; level, held until its next enable
ov_sample  out  LENGTH  held sample to FIR core
o_sample_valid  out  1  ov_sample valid
i_sample_ready  in  1  FIR core accepts sample
o_frame_err  out  1  one-cycle pulse on a framing error
o_overrun  out  1  one-cycle pulse when a captured word is dropped
ov_err_cnt  out  ERR_W  saturating count of frame errors plus overruns

Behaviour:
- Reset (async): state=IDLE, bit_cnt=0. All o_* and ov_* outputs are 0, including the edge-detect register.
- The deserializer uses a synchronous reset, so it is driven from the same i_rst net.
- Deserializer drive: o_deser_en, o_deser_din and o_deser_din_valid are registered one cycle after the accepted strobe. o_deser_en is a single-cycle pulse.
- Bits are not forwarded in IDLE, or in HUNT without sync.
- FSM states:
  - IDLE: no strobes forwarded. i_run=1 -> HUNT.
  - HUNT: strobe with sync=1 -> forward bit, bit_cnt=1, go to SHIFT. Strobe with sync=0 -> ignore.
  - SHIFT: each strobe forwards one bit and increments bit_cnt.
    - When the forwarded bit is bit LENGTH-1, o_deser_din_valid=1 with that bit and bit_cnt wraps to 0.
    - Strobe with sync=1 while bit_cnt!=0 (early sync): pulse o_frame_err. Treat the bit as bit 0 of a new word (forward it, bit_cnt=1). No flush is needed because the partial bits are shifted out before the next word-valid.
    - Strobe with sync=0 while bit_cnt==0 (missing sync): pulse o_frame_err, drop the bit, go to HUNT.
    - Strobe with sync=1 while bit_cnt==0: normal back-to-back word.
- i_run=0 in any state -> IDLE next cycle, bit_cnt=0. The in-flight partial word is abandoned. Already-captured words and the held sample are kept.
- Capture: on a rising edge of i_deser_dout_valid (current=1, previous=0), load iv_deser_dout into the holding register.
  - This is 2 cycles after the final-bit strobe.
  - The capture always shows the full word: LSB-first order, first bit lands in bit 0.
- Holding register handshake:
  - Capture with o_sample_valid=0 -> load, valid=1.
  - Capture with valid=1 and i_sample_ready=1 in the same cycle -> load the new word, valid stays 1.
  - Capture with valid=1 and i_sample_ready=0 -> drop the new word, keep the old one, pulse o_overrun.
  - No capture with valid=1 and i_sample_ready=1 -> valid=0.
- ov_err_cnt: +1 per o_frame_err or o_overrun pulse. When both pulse in the same cycle, +2. The count saturates at all-ones.

Decomposition:
- Shared package holds the FSM state encoding localparams (IDLE, HUNT, SHIFT) and the bit-counter width, clog2(LENGTH).
- Sub-module: deser_sample_buf, the holding register with the valid/ready handshake, overrun detection and rising-edge capture.
- The testbench instantiates this block together with the deserializer.

Test Plan:
- Reset, then i_run=1. Send 24 strobes of 0xA5C3F0 LSB-first, sync on bit 0 -> ov_sample=0xA5C3F0 and o_sample_valid=1 three cycles after the last strobe, ov_err_cnt=0.
- Two back-to-back words 0x000001 then 0x800000, i_sample_ready=1 on each valid -> both delivered in order, no o_overrun.
- Sync asserted on bit 10 of a word -> one o_frame_err pulse. The following full word 0x123456 is delivered correctly, ov_err_cnt=1.
- No sync on the bit after bit 23 -> o_frame_err and state HUNT. Strobes ignored until the next sync, then the word is received correctly.
- Hold i_sample_ready=0 across two words 0x111111 and 0x222222 -> ov_sample stays 0x111111, o_overrun pulses once, ov_err_cnt=1.
- Deassert i_run at bit 12, reassert, send 0xABCDEF with sync -> no valid for the partial word, 0xABCDEF delivered. Assert i_rst mid-word -> all outputs 0 immediately.
